// File: rtl/btn_event_unit.sv
// Debounces four raw buttons and queues one 2-bit code per press, popped via valid/ready.
// Optional BTN_EVT_FIFO_EN selects a 4-deep FIFO; otherwise a single holding register.
module btn_event_unit #(
   parameter int DB_CYCLES = 1000000,
   parameter int CNT_W     = 20
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] btn_raw,
   output logic       evt_valid,
   output logic [1:0] evt_val,
   input  logic       evt_ready,
   output logic [3:0] btn_level,
   output logic       evt_drop
);

   typedef enum logic {IDLE, HELD} state_t;

   logic [3:0]            sync1_q, sync2_q;
   logic [3:0]            stable_q, stable_d;
   logic [3:0][CNT_W-1:0] cnt_q, cnt_d;
   state_t                state_q, state_d;
   logic                  push;
   logic [1:0]            push_code;
   logic                  pop;
   logic                  accept;
   logic                  drop_q, drop_d;

   always_comb begin
      stable_d = stable_q;
      cnt_d    = '0;
      for (int b = 0; b < 4; b++) begin
         if (sync2_q[b] != stable_q[b]) begin
            // Toggle on the cycle the count would reach DB_CYCLES-1.
            if (cnt_q[b] == CNT_W'(DB_CYCLES - 2)) begin
               stable_d[b] = ~stable_q[b];
            end else begin
               cnt_d[b] = cnt_q[b] + 1'b1;
            end
         end
      end
   end

   always_comb begin
      push_code = 2'd3;
      if (stable_q[0])      push_code = 2'd0;
      else if (stable_q[1]) push_code = 2'd1;
      else if (stable_q[2]) push_code = 2'd2;
   end

   always_comb begin
      state_d = state_q;
      push    = 1'b0;
      case (state_q)
         IDLE: if (stable_q != 4'd0) begin
            push    = 1'b1;
            state_d = HELD;
         end
         HELD: if (stable_q == 4'd0) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1_q  <= '0;
         sync2_q  <= '0;
         stable_q <= '0;
         cnt_q    <= '0;
         state_q  <= IDLE;
         drop_q   <= 1'b0;
      end else begin
         sync1_q  <= btn_raw;
         sync2_q  <= sync1_q;
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
         state_q  <= state_d;
         drop_q   <= drop_d;
      end
   end

`ifdef BTN_EVT_FIFO_EN
   logic [1:0] mem_q [4];
   logic [1:0] wr_ptr_q, rd_ptr_q;
   logic [2:0] count_q;
   logic       full;

   assign full   = (count_q == 3'd4);
   assign pop    = (count_q != 3'd0) & evt_ready;
   // A pop on a full queue frees the slot for a same-cycle push.
   assign accept = push & (~full | pop);
   assign drop_d = push & full & ~pop;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (accept) begin
            mem_q[wr_ptr_q] <= push_code;
            wr_ptr_q        <= wr_ptr_q + 2'd1;
         end
         if (pop) rd_ptr_q <= rd_ptr_q + 2'd1;
         count_q <= count_q + {2'b00, accept} - {2'b00, pop};
      end
   end

   assign evt_valid = (count_q != 3'd0);
   assign evt_val   = mem_q[rd_ptr_q];
`else
   logic       full_q;
   logic [1:0] dat_q;

   assign pop    = full_q & evt_ready;
   assign accept = push & (~full_q | pop);
   assign drop_d = push & full_q & ~pop;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         full_q <= 1'b0;
         dat_q  <= '0;
      end else begin
         full_q <= accept | (full_q & ~pop);
         if (accept) dat_q <= push_code;
      end
   end

   assign evt_valid = full_q;
   assign evt_val   = dat_q;
`endif

   assign btn_level = stable_q;
   assign evt_drop  = drop_q;

endmodule

// File: tb/tb_btn_event_unit.sv
// Bench for btn_event_unit: directed vector table, corner sequences, random run against a queue-based model.
module tb_btn_event_unit;

   localparam int DB = 4;
`ifdef BTN_EVT_FIFO_EN
   localparam int DEPTH = 4;
`else
   localparam int DEPTH = 1;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] btn_raw;
   logic       evt_valid;
   logic [1:0] evt_val;
   logic       evt_ready;
   logic [3:0] btn_level;
   logic       evt_drop;

   btn_event_unit #(.DB_CYCLES(DB), .CNT_W(3)) dut (
      .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw),
      .evt_valid(evt_valid), .evt_val(evt_val), .evt_ready(evt_ready),
      .btn_level(btn_level), .evt_drop(evt_drop)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: sync pipeline, disagreement run lengths, held flag, event queue.
   logic [3:0] m_s1, m_s2, m_stable;
   int         m_run [4];
   bit         m_held;
   logic [1:0] m_q [$];
   bit         m_drop;

   logic [1:0] popped [$];
   int         drops_seen;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step();
      bit         pop, press, ndrop;
      logic [1:0] code;
      if (!rst_n) begin
         m_s1 = 0; m_s2 = 0; m_stable = 0; m_held = 0; m_drop = 0;
         for (int b = 0; b < 4; b++) m_run[b] = 0;
         m_q.delete();
         return;
      end
      pop   = (m_q.size() > 0) && evt_ready;
      press = !m_held && (m_stable != 0);
      code  = 0;
      for (int b = 3; b >= 0; b--) if (m_stable[b]) code = 2'(b);
      ndrop = press && (m_q.size() == DEPTH) && !pop;
      if (pop) void'(m_q.pop_front());
      if (press && m_q.size() < DEPTH) m_q.push_back(code);
      m_drop = ndrop;
      if (!m_held && m_stable != 0) m_held = 1;
      else if (m_held && m_stable == 0) m_held = 0;
      // A level flips after DB-1 consecutive cycles of disagreement.
      for (int b = 0; b < 4; b++) begin
         if (m_s2[b] != m_stable[b]) begin
            m_run[b]++;
            if (m_run[b] == DB - 1) begin
               m_stable[b] = ~m_stable[b];
               m_run[b] = 0;
            end
         end else begin
            m_run[b] = 0;
         end
      end
      m_s2 = m_s1;
      m_s1 = btn_raw;
   endtask

   task automatic tick();
      if (evt_valid === 1'b1 && evt_ready === 1'b1) popped.push_back(evt_val);
      @(posedge clk);
      model_step();
      @(negedge clk);
      chk("evt_valid", {31'd0, evt_valid}, {31'd0, m_q.size() > 0});
      if (m_q.size() > 0) chk("evt_val", {30'd0, evt_val}, {30'd0, m_q[0]});
      chk("btn_level", {28'd0, btn_level}, {28'd0, m_stable});
      chk("evt_drop", {31'd0, evt_drop}, {31'd0, m_drop});
      if (evt_drop === 1'b1) drops_seen++;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   typedef struct {
      logic       rst_n;
      logic [3:0] raw;
      logic       rdy;
      logic       vld;
      logic [1:0] val;
      logic [3:0] lvl;
      logic       drop;
   } vec_t;

   vec_t vt [9];

   initial begin
      int hold;
      vt[0] = '{1'b0, 4'hF, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0};
      vt[1] = '{1'b0, 4'hF, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0};
      vt[2] = '{1'b1, 4'hF, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0};
      vt[3] = '{1'b1, 4'hF, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0};
      vt[4] = '{1'b1, 4'hF, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0};
      vt[5] = '{1'b1, 4'hF, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0};
      vt[6] = '{1'b1, 4'hF, 1'b0, 1'b0, 2'd0, 4'hF, 1'b0};
      vt[7] = '{1'b1, 4'hF, 1'b0, 1'b1, 2'd0, 4'hF, 1'b0};
      vt[8] = '{1'b1, 4'hF, 1'b0, 1'b1, 2'd0, 4'hF, 1'b0};

      rst_n = 1'b0; btn_raw = 4'h0; evt_ready = 1'b0; drops_seen = 0;
      @(negedge clk);

      // Reset with all buttons held, then first event six edges after release.
      for (int i = 0; i < 9; i++) begin
         rst_n = vt[i].rst_n; btn_raw = vt[i].raw; evt_ready = vt[i].rdy;
         tick();
         chk($sformatf("vec%0d_vld", i), {31'd0, evt_valid}, {31'd0, vt[i].vld});
         chk($sformatf("vec%0d_val", i), {30'd0, evt_val}, {30'd0, vt[i].val});
         chk($sformatf("vec%0d_lvl", i), {28'd0, btn_level}, {28'd0, vt[i].lvl});
         chk($sformatf("vec%0d_drop", i), {31'd0, evt_drop}, {31'd0, vt[i].drop});
      end
      btn_raw = 4'h0; evt_ready = 1'b1;
      ticks(12);

      // Single press, release, re-press.
      popped.delete();
      btn_raw = 4'b0100; ticks(20);
      chk("single_count1", popped.size(), 1);
      if (popped.size() > 0) chk("single_code1", {30'd0, popped[0]}, 32'd2);
      btn_raw = 4'b0000; ticks(10);
      btn_raw = 4'b0100; ticks(12);
      chk("single_count2", popped.size(), 2);
      if (popped.size() > 1) chk("single_code2", {30'd0, popped[1]}, 32'd2);
      btn_raw = 4'b0000; ticks(10);

      // Two-cycle glitch is rejected.
      popped.delete();
      btn_raw = 4'b0010; ticks(2);
      btn_raw = 4'b0000; ticks(10);
      chk("glitch_events", popped.size(), 0);

      // Simultaneous press resolves to lowest index; extra presses while held are ignored.
      btn_raw = 4'b1010; ticks(10);
      btn_raw = 4'b0010; ticks(10);
      btn_raw = 4'b1010; ticks(10);
      chk("simul_count", popped.size(), 1);
      if (popped.size() > 0) chk("simul_code", {30'd0, popped[0]}, 32'd1);
      btn_raw = 4'b0000; ticks(10);

      // Overflow: five presses with no consumer.
      popped.delete(); drops_seen = 0; evt_ready = 1'b0;
      for (int p = 0; p < 5; p++) begin
         btn_raw = 4'b0001; ticks(10);
         btn_raw = 4'b0000; ticks(10);
      end
      chk("ovf_drops", drops_seen, 5 - DEPTH);
      evt_ready = 1'b1; ticks(8);
      chk("ovf_drained", popped.size(), DEPTH);

      // Full queue: push lands on the same edge as a pop.
      popped.delete(); drops_seen = 0; evt_ready = 1'b0;
      for (int p = 0; p < DEPTH; p++) begin
         btn_raw = 4'b0001; ticks(10);
         btn_raw = 4'b0000; ticks(10);
      end
      btn_raw = 4'b1000; ticks(5);
      evt_ready = 1'b1; tick();
      evt_ready = 1'b0; ticks(4);
      chk("fullpp_drops", drops_seen, 0);
      btn_raw = 4'b0000; ticks(10);
      evt_ready = 1'b1; ticks(8);
      chk("fullpp_count", popped.size(), DEPTH + 1);
      if (popped.size() > 0) chk("fullpp_last", {30'd0, popped[popped.size()-1]}, 32'd3);

      // Random traffic with a reset in the middle.
      hold = 0;
      for (int i = 0; i < 1500; i++) begin
         if (hold == 0) begin
            btn_raw = 4'($urandom);
            hold = $urandom_range(1, 12);
         end
         hold--;
         evt_ready = ($urandom_range(0, 3) != 0);
         rst_n = !(i == 700 || i == 701);
         tick();
      end
      rst_n = 1'b1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
